shift_reg_univ: RTL and testbench

Parametrised universal shift register: the successor of the fixed 4-bit serial-in/parallel-out practice register. Width and reset value are parameters. It supports hold, shift right, shift left and parallel load, and exposes the bit shifted out. A word counter pulses `word_valid` each time a full word has been shifted in one direction. It sits between a serial source (switch/UART-style bit stream) and parallel consumers (LEDs, 7-segment decoder), or drives a serial line from a parallel word.

---
 rtl/shift_reg_univ_pkg.sv | 26 ++
 rtl/shift_word_cnt.sv | 67 ++++++
 rtl/shift_reg_univ.sv | 103 ++++++++++
 tb/tb_shift_reg_univ.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_univ_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_univ_pkg
// Shared definitions for the universal shift register and its word counter.
//   mode_e      : operation select codes (hold / shift right / shift left / load)
//   DIR_RIGHT,
//   DIR_LEFT    : shift direction encoding used by the word counter
//   cnt_width() : width of a counter that must be able to hold the value w
// -----------------------------------------------------------------------------
package shift_reg_univ_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // The count has to represent WIDTH itself for the terminal compare.
    function automatic int cnt_width(input int w);
        return (w < 1) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_word_cnt.sv
// -----------------------------------------------------------------------------
// shift_word_cnt
// Counts consecutive same-direction shifts and pulses word_valid when WIDTH of
// them have completed. Owns the count and the last-direction state.
// Ports:
//   clk        in  : clock, rising edge
//   rst        in  : synchronous active-high reset (count=0, last dir=right)
//   shift_en   in  : a shift happens on this edge
//   dir        in  : direction of that shift (DIR_RIGHT / DIR_LEFT)
//   clear      in  : parallel load; restart count, keep last direction
//   word_valid out : registered one-cycle pulse on word completion
// -----------------------------------------------------------------------------
module shift_word_cnt
    import shift_reg_univ_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic dir,
    input  logic clear,
    output logic word_valid
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [CW-1:0] count_q, count_d, count_next;
    logic          last_dir_q, last_dir_d;
    logic          valid_q, valid_d;

    // A direction change counts the switching shift itself, hence 1 not 0.
    assign count_next = (dir != last_dir_q) ? CW'(1) : count_q + CW'(1);

    always_comb begin
        count_d    = count_q;
        last_dir_d = last_dir_q;
        valid_d    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (shift_en) begin
            last_dir_d = dir;
            if (count_next == CNT_MAX) begin
                valid_d = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            last_dir_q <= DIR_RIGHT;
            valid_q    <= 1'b0;
        end else begin
            count_q    <= count_d;
            last_dir_q <= last_dir_d;
            valid_q    <= valid_d;
        end
    end

    assign word_valid = valid_q;

endmodule

// File: rtl/shift_reg_univ.sv
// -----------------------------------------------------------------------------
// shift_reg_univ
// Parametrised universal shift register: hold, shift right, shift left and
// parallel load, with the shifted-out bit and a word-complete pulse.
// Ports:
//   clk        in           : clock, rising edge
//   rst        in           : synchronous active-high reset, highest priority
//   mode       in  [1:0]    : 00 hold, 01 shift right, 10 shift left, 11 load
//   data_in    in           : serial input bit
//   par_in     in  [WIDTH]  : parallel load word
//   data_out   out [WIDTH]  : register contents (registered)
//   ser_out    out          : bit shifted out on the most recent shift (registered)
//   word_valid out          : pulse when WIDTH same-direction shifts completed
// All outputs come straight from flops; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module shift_reg_univ
    import shift_reg_univ_pkg::*;
#(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             data_in,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic             word_valid
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             ser_q, ser_d;
    logic [WIDTH-1:0] shr_word, shl_word;
    logic             shift_en, shift_dir, cnt_clear;

    // A 1-bit register has no neighbours to shift in from; both directions
    // simply capture the serial input.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shr_word = data_in;
            assign shl_word = data_in;
        end else begin : g_wn
            assign shr_word = {data_in, data_q[WIDTH-1:1]};
            assign shl_word = {data_q[WIDTH-2:0], data_in};
        end
    endgenerate

    always_comb begin
        data_d    = data_q;
        ser_d     = ser_q;
        shift_en  = 1'b0;
        shift_dir = DIR_RIGHT;
        cnt_clear = 1'b0;
        case (mode_e'(mode))
            MODE_SHR: begin
                data_d    = shr_word;
                ser_d     = data_q[0];
                shift_en  = 1'b1;
                shift_dir = DIR_RIGHT;
            end
            MODE_SHL: begin
                data_d    = shl_word;
                ser_d     = data_q[WIDTH-1];
                shift_en  = 1'b1;
                shift_dir = DIR_LEFT;
            end
            MODE_LOAD: begin
                data_d    = par_in;
                cnt_clear = 1'b1;
            end
            default: begin
                // hold: everything keeps its value
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= INIT;
            ser_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            ser_q  <= ser_d;
        end
    end

    shift_word_cnt #(
        .WIDTH (WIDTH)
    ) u_word_cnt (
        .clk        (clk),
        .rst        (rst),
        .shift_en   (shift_en),
        .dir        (shift_dir),
        .clear      (cnt_clear),
        .word_valid (word_valid)
    );

    assign data_out = data_q;
    assign ser_out  = ser_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
module tb_shift_reg_univ;
  import shift_reg_univ_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit instance, INIT = 0
  logic       rst4 = 1'b0;
  logic [1:0] mode4 = MODE_HOLD;
  logic       din4 = 1'b0;
  logic [3:0] par4 = '0;
  logic [3:0] dout4;
  logic       ser4, wv4;

  // 8-bit instance, INIT = FF
  logic       rst8 = 1'b0;
  logic [1:0] mode8 = MODE_HOLD;
  logic       din8 = 1'b0;
  logic [7:0] par8 = '0;
  logic [7:0] dout8;
  logic       ser8, wv8;

  shift_reg_univ #(.WIDTH(4), .INIT(4'h0)) dut4 (
    .clk(clk), .rst(rst4), .mode(mode4), .data_in(din4), .par_in(par4),
    .data_out(dout4), .ser_out(ser4), .word_valid(wv4)
  );

  shift_reg_univ #(.WIDTH(8), .INIT(8'hFF)) dut8 (
    .clk(clk), .rst(rst8), .mode(mode8), .data_in(din8), .par_in(par8),
    .data_out(dout8), .ser_out(ser8), .word_valid(wv8)
  );

  // ---------------- scoreboard ----------------
  // expected entry packs {data, ser_out, word_valid}
  logic [5:0] exp_q[$];
  logic [9:0] exp8_q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag);
    logic [5:0] e;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      chkw({tag, ".data"}, {4'h0, dout4}, {4'h0, e[5:2]});
      chk1({tag, ".ser"}, ser4, e[1]);
      chk1({tag, ".wv"}, wv4, e[0]);
    end
  endtask

  task automatic check8(input string tag);
    logic [9:0] e;
    if (exp8_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp8_q.pop_front();
      chkw({tag, ".data"}, dout8, e[9:2]);
      chk1({tag, ".ser"}, ser8, e[1]);
      chk1({tag, ".wv"}, wv8, e[0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one edge on the 4-bit DUT; expected outputs are pushed first and
  // compared 1 time unit after the edge.
  task automatic step4(input string tag, input logic r, input logic [1:0] m,
                       input logic d, input logic [3:0] p,
                       input logic [3:0] e_data, input logic e_ser, input logic e_wv);
    exp_q.push_back({e_data, e_ser, e_wv});
    rst4 = r; mode4 = m; din4 = d; par4 = p;
    @(posedge clk);
    #1;
    rst4 = 1'b0; mode4 = MODE_HOLD;
    check4(tag);
  endtask

  task automatic step8(input string tag, input logic r, input logic [1:0] m,
                       input logic d, input logic [7:0] e_data,
                       input logic e_ser, input logic e_wv);
    exp8_q.push_back({e_data, e_ser, e_wv});
    rst8 = r; mode8 = m; din8 = d;
    @(posedge clk);
    #1;
    rst8 = 1'b0; mode8 = MODE_HOLD;
    check8(tag);
  endtask

  // ---------------- directed sequence ----------------
  logic [3:0] m_data;
  logic       m_ser;
  logic       rb;
  logic [7:0] m8;

  initial begin
    @(negedge clk);

    // reset state
    step4("rst", 1, MODE_HOLD, 0, 4'h0, 4'b0000, 0, 0);

    // shift right 1,0,1,1
    step4("shr1", 0, MODE_SHR, 1, 4'h0, 4'b1000, 0, 0);
    step4("shr2", 0, MODE_SHR, 0, 4'h0, 4'b0100, 0, 0);
    step4("shr3", 0, MODE_SHR, 1, 4'h0, 4'b1010, 0, 0);
    step4("shr4", 0, MODE_SHR, 1, 4'h0, 4'b1101, 0, 1);

    // shift left 1,0,1,1
    step4("rst2", 1, MODE_HOLD, 0, 4'h0, 4'b0000, 0, 0);
    step4("shl1", 0, MODE_SHL, 1, 4'h0, 4'b0001, 0, 0);
    step4("shl2", 0, MODE_SHL, 0, 4'h0, 4'b0010, 0, 0);
    step4("shl3", 0, MODE_SHL, 1, 4'h0, 4'b0101, 0, 0);
    step4("shl4", 0, MODE_SHL, 1, 4'h0, 4'b1011, 0, 1);

    // load then two right shifts
    step4("ld",   0, MODE_LOAD, 0, 4'b1010, 4'b1010, 0, 0);
    step4("ldr1", 0, MODE_SHR,  0, 4'h0,    4'b0101, 0, 0);
    step4("ldr2", 0, MODE_SHR,  0, 4'h0,    4'b0010, 1, 0);

    // two right, hold, four left
    step4("rst3", 1, MODE_HOLD, 0, 4'h0, 4'b0000, 0, 0);
    step4("dr1",  0, MODE_SHR,  1, 4'h0, 4'b1000, 0, 0);
    step4("dr2",  0, MODE_SHR,  1, 4'h0, 4'b1100, 0, 0);
    step4("dh",   0, MODE_HOLD, 0, 4'h0, 4'b1100, 0, 0);
    step4("dl1",  0, MODE_SHL,  0, 4'h0, 4'b1000, 1, 0);
    step4("dl2",  0, MODE_SHL,  0, 4'h0, 4'b0000, 1, 0);
    step4("dl3",  0, MODE_SHL,  0, 4'h0, 4'b0000, 0, 0);
    step4("dl4",  0, MODE_SHL,  0, 4'h0, 4'b0000, 0, 1);

    // partial word discarded by reset
    step4("rst4", 1, MODE_HOLD, 0, 4'h0, 4'b0000, 0, 0);
    step4("pr1",  0, MODE_SHR,  1, 4'h0, 4'b1000, 0, 0);
    step4("pr2",  0, MODE_SHR,  1, 4'h0, 4'b1100, 0, 0);
    step4("pr3",  0, MODE_SHR,  1, 4'h0, 4'b1110, 0, 0);
    step4("prst", 1, MODE_SHR,  1, 4'h0, 4'b0000, 0, 0);
    step4("pa1",  0, MODE_SHR,  0, 4'h0, 4'b0000, 0, 0);
    step4("pa2",  0, MODE_SHR,  0, 4'h0, 4'b0000, 0, 0);
    step4("pa3",  0, MODE_SHR,  0, 4'h0, 4'b0000, 0, 0);
    step4("pa4",  0, MODE_SHR,  0, 4'h0, 4'b0000, 0, 1);

    // eight continuous right shifts with random serial bits
    step4("rst5", 1, MODE_HOLD, 0, 4'h0, 4'b0000, 0, 0);
    m_data = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      rb = 1'($urandom_range(0, 1));
      m_ser = m_data[0];
      m_data = {rb, m_data[3:1]};
      step4("cont", 0, MODE_SHR, rb, 4'h0, m_data, m_ser, (i == 3 || i == 7));
    end

    // load right after the pulse, then a full word again
    step4("ldp", 0, MODE_LOAD, 0, 4'b0110, 4'b0110, m_ser, 0);
    m_data = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      rb = 1'($urandom_range(0, 1));
      m_ser = m_data[0];
      m_data = {rb, m_data[3:1]};
      step4("aftld", 0, MODE_SHR, rb, 4'h0, m_data, m_ser, (i == 3));
    end

    // WIDTH=8, INIT=FF
    step8("w8rst", 1, MODE_HOLD, 0, 8'hFF, 0, 0);
    m8 = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      m8 = {1'b0, m8[7:1]};
      step8("w8shr", 0, MODE_SHR, 0, m8, 1, (i == 7));
    end
    step8("w8shr9", 0, MODE_SHR, 0, 8'h00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // hard time limit
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
